// File: rtl/qea_readout_pkg.sv
// Shared definitions for the QEA state readout block.
//   rd_state_e     : readout sequencer states.
//   ONE_FX         : fixed-point 1.0 for amplitudes and probabilities.
//   last_word_addr : address of the last state RAM word for a qubit count,
//                    with the small-circuit and oversize-circuit clamps applied.
package qea_readout_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_EMIT,
        S_DONE
    } rd_state_e;

    localparam int unsigned QEA_FRAC_BIT = 30;
    localparam logic [31:0] ONE_FX       = 32'(1) << QEA_FRAC_BIT;

    // Word count is 2^(qbit_num - pe_num_width). The function returns that
    // count minus one, so the caller can compare directly against the address.
    function automatic int unsigned last_word_addr(input int unsigned qbit_num,
                                                   input int unsigned pe_num_width,
                                                   input int unsigned addr_width);
        if (qbit_num <= pe_num_width) begin
            return 0;
        end
        if (qbit_num - pe_num_width >= addr_width) begin
            return 32'hFFFF_FFFF >> (32 - addr_width);
        end
        return (32'd1 << (qbit_num - pe_num_width)) - 1;
    endfunction

endpackage

// File: rtl/qea_amp_to_prob.sv
// Combinational complex amplitude to probability converter.
//   i_amp  : {re, im}, each a signed DATA_WIDTH fixed-point value, re in the upper half.
//   o_prob : (re^2 + im^2) >> NUM_FRAC_BIT, saturated to DATA_WIDTH unsigned bits.
module qea_amp_to_prob #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_FRAC_BIT = 30
) (
    input  logic [2*DATA_WIDTH-1:0] i_amp,
    output logic [DATA_WIDTH-1:0]   o_prob
);

    localparam int P2_W = 2*DATA_WIDTH + 1;

    logic signed [DATA_WIDTH-1:0]   re;
    logic signed [DATA_WIDTH-1:0]   im;
    logic signed [2*DATA_WIDTH-1:0] re_x;
    logic signed [2*DATA_WIDTH-1:0] im_x;
    logic signed [2*DATA_WIDTH-1:0] re_sq;
    logic signed [2*DATA_WIDTH-1:0] im_sq;
    logic [P2_W-1:0]                p2;

    function automatic logic [DATA_WIDTH-1:0] sat_prob(input logic [P2_W-1:0] val);
        logic [P2_W-1:0] shifted;
        shifted = val >> NUM_FRAC_BIT;
        if (|shifted[P2_W-1:DATA_WIDTH]) begin
            return '1;
        end
        return shifted[DATA_WIDTH-1:0];
    endfunction

    assign re    = i_amp[2*DATA_WIDTH-1:DATA_WIDTH];
    assign im    = i_amp[DATA_WIDTH-1:0];
    assign re_x  = (2*DATA_WIDTH)'(re);
    assign im_x  = (2*DATA_WIDTH)'(im);
    // Squares are never negative; the most negative input squares to 2^(2W-2),
    // which still fits the signed product width.
    assign re_sq = re_x * re_x;
    assign im_sq = im_x * im_x;
    assign p2    = {1'b0, re_sq} + {1'b0, im_sq};

    assign o_prob = sat_prob(p2);

endmodule

// File: rtl/qea_state_readout.sv
// QEA state readout: after the core completes, sweeps the state RAM, streams
// one probability per basis state over valid/ready, and reports the total
// probability and the argmax basis index at the end of the sweep.
//   clk, rst                 : clock, synchronous active-high reset.
//   i_start, i_qbit_num      : sweep trigger pulse and qubit count (latched on start).
//   o_state_ena/wea/addra    : state RAM read port controls (never writes).
//   i_state_dout             : PE_NUM amplitudes per word, slot p at bits [(p+1)*SDW-1 : p*SDW].
//   o_valid, i_ready         : probability stream handshake.
//   o_prob, o_index, o_last  : probability beat, its basis index, final-beat flag.
//   o_busy, o_done           : sweep in progress, one-cycle completion pulse.
//   o_sum, o_argmax          : saturated probability total and argmax index.
module qea_state_readout
    import qea_readout_pkg::*;
#(
    parameter int PE_NUM_WIDTH     = 2,
    parameter int PE_NUM           = 4,
    parameter int DATA_WIDTH       = 32,
    parameter int STATE_DATA_WIDTH = DATA_WIDTH*2,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH   = 6,
    parameter int NUM_FRAC_BIT     = 30,
    parameter int RAM_RD_LAT       = 1,
    parameter int SUM_WIDTH        = DATA_WIDTH+8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_start,
    input  logic [MAX_QBIT_WIDTH-1:0]             i_qbit_num,
    output logic [PE_NUM-1:0]                     o_state_ena,
    output logic [PE_NUM-1:0]                     o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]           o_state_addra,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]    i_state_dout,
    output logic                                  o_valid,
    input  logic                                  i_ready,
    output logic [DATA_WIDTH-1:0]                 o_prob,
    output logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] o_index,
    output logic                                  o_last,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic [SUM_WIDTH-1:0]                  o_sum,
    output logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] o_argmax
);

    localparam int IDX_W  = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
    localparam int BUF_W  = PE_NUM * STATE_DATA_WIDTH;
    localparam int WAIT_W = (RAM_RD_LAT > 1) ? $clog2(RAM_RD_LAT) : 1;

    rd_state_e                   state_q,     state_d;
    logic [STATE_ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [STATE_ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic [WAIT_W-1:0]           wait_q,      wait_d;
    logic [BUF_W-1:0]            buf_q,       buf_d;
    logic [PE_NUM_WIDTH-1:0]     slot_q,      slot_d;
    logic                        valid_q,     valid_d;
    logic [DATA_WIDTH-1:0]       prob_q,      prob_d;
    logic [IDX_W-1:0]            index_q,     index_d;
    logic                        last_q,      last_d;
    logic [SUM_WIDTH-1:0]        sum_q,       sum_d;
    logic [DATA_WIDTH-1:0]       max_q,       max_d;
    logic [IDX_W-1:0]            argmax_q,    argmax_d;

    logic [PE_NUM_WIDTH-1:0]     next_slot;
    logic [STATE_DATA_WIDTH-1:0] cur_amp;
    logic [DATA_WIDTH-1:0]       cur_prob;

    function automatic logic [SUM_WIDTH-1:0] sat_add(input logic [SUM_WIDTH-1:0]  acc,
                                                     input logic [DATA_WIDTH-1:0] inc);
        logic [SUM_WIDTH:0] s;
        s = {1'b0, acc} + (SUM_WIDTH+1)'(inc);
        return s[SUM_WIDTH] ? '1 : s[SUM_WIDTH-1:0];
    endfunction

    // The output register is loaded with slot 0 on EMIT entry (valid low) and
    // with the following slot after every accepted beat.
    assign next_slot = valid_q ? slot_q + 1'b1 : '0;
    assign cur_amp   = buf_q[next_slot*STATE_DATA_WIDTH +: STATE_DATA_WIDTH];

    qea_amp_to_prob #(
        .DATA_WIDTH   (DATA_WIDTH),
        .NUM_FRAC_BIT (NUM_FRAC_BIT)
    ) u_amp_to_prob (
        .i_amp  (cur_amp),
        .o_prob (cur_prob)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        wait_d      = wait_q;
        buf_d       = buf_q;
        slot_d      = slot_q;
        valid_d     = valid_q;
        prob_d      = prob_q;
        index_d     = index_q;
        last_d      = last_q;
        sum_d       = sum_q;
        max_d       = max_q;
        argmax_d    = argmax_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    last_addr_d = STATE_ADDR_WIDTH'(last_word_addr(int'(i_qbit_num),
                                                                   PE_NUM_WIDTH,
                                                                   STATE_ADDR_WIDTH));
                    addr_d      = '0;
                    sum_d       = '0;
                    max_d       = '0;
                    argmax_d    = '0;
                    state_d     = S_READ;
                end
            end
            S_READ: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == WAIT_W'(RAM_RD_LAT-1)) begin
                    buf_d   = i_state_dout;
                    state_d = S_EMIT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_EMIT: begin
                if (valid_q && i_ready) begin
                    sum_d = sat_add(sum_q, prob_q);
                    // Strictly greater keeps the lowest index on ties.
                    if (prob_q > max_q) begin
                        max_d    = prob_q;
                        argmax_d = index_q;
                    end
                end
                if (valid_q && i_ready && slot_q == PE_NUM_WIDTH'(PE_NUM-1)) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (addr_q == last_addr_q) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_READ;
                    end
                end else if (!valid_q || i_ready) begin
                    valid_d = 1'b1;
                    slot_d  = next_slot;
                    prob_d  = cur_prob;
                    index_d = {addr_q, next_slot};
                    last_d  = (addr_q == last_addr_q) &&
                              (next_slot == PE_NUM_WIDTH'(PE_NUM-1));
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            wait_q      <= '0;
            buf_q       <= '0;
            slot_q      <= '0;
            valid_q     <= 1'b0;
            prob_q      <= '0;
            index_q     <= '0;
            last_q      <= 1'b0;
            sum_q       <= '0;
            max_q       <= '0;
            argmax_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            wait_q      <= wait_d;
            buf_q       <= buf_d;
            slot_q      <= slot_d;
            valid_q     <= valid_d;
            prob_q      <= prob_d;
            index_q     <= index_d;
            last_q      <= last_d;
            sum_q       <= sum_d;
            max_q       <= max_d;
            argmax_q    <= argmax_d;
        end
    end

    assign o_state_ena   = {PE_NUM{state_q == S_READ}};
    assign o_state_wea   = '0;
    assign o_state_addra = addr_q;
    assign o_valid       = valid_q;
    assign o_prob        = prob_q;
    assign o_index       = index_q;
    assign o_last        = last_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = (state_q == S_DONE);
    assign o_sum         = sum_q;
    assign o_argmax      = argmax_q;

endmodule

// File: doc/qea_state_readout.md
Name: qea_state_readout

Overview:
- Downstream consumer of the QEA core. After the core raises its completion flag, this block sweeps the QEA state RAM through the core's state port.
- Converts each complex amplitude to a fixed-point probability (re²+im²) and streams one probability per basis state over a valid/ready interface.
- Reports the total probability and the argmax basis index at the end of the sweep.
- Replaces the manual post-run state dump with hardware readout for measurement and quanvolutional feature extraction.

Parameters:
- PE_NUM_WIDTH, 2, log2 of PE_NUM.
- PE_NUM, 4, amplitudes per state RAM word.
- DATA_WIDTH, 32, width of each real/imag component.
- STATE_DATA_WIDTH, DATA_WIDTH*2, one amplitude: {re, im}, re in the upper half.
- STATE_ADDR_WIDTH, 16, state RAM word address width.
- MAX_QBIT_WIDTH, 6, width of the qubit-count input.
- NUM_FRAC_BIT, 30, fractional bits of amplitude and probability (1.0 = 0x40000000).
- RAM_RD_LAT, 1, state RAM read latency in cycles.
- SUM_WIDTH, DATA_WIDTH+8, width of the probability accumulator.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- i_start  in  1  one-cycle pulse, driven from the QEA o_complete rising edge.
- i_qbit_num  in  MAX_QBIT_WIDTH  qubit count of the finished circuit.
- o_state_ena  out  PE_NUM  state RAM enable, all bits driven together.
- o_state_wea  out  PE_NUM  state RAM write enable, constant 0.
- o_state_addra  out  STATE_ADDR_WIDTH  state RAM word address.
- i_state_dout  in  PE_NUM*STATE_DATA_WIDTH  state RAM read data.
- o_valid  out  1  probability beat valid.
- i_ready  in  1  downstream ready.
- o_prob  out  DATA_WIDTH  unsigned probability, NUM_FRAC_BIT fractional bits.
- o_index  out  STATE_ADDR_WIDTH+PE_NUM_WIDTH  basis index of o_prob.
- o_last  out  1  final beat of the sweep.
- o_busy  out  1  sweep in progress.
- o_done  out  1  one-cycle pulse when the sweep completes.
- o_sum  out  SUM_WIDTH  sum of all emitted probabilities; valid from o_done until the next start.
- o_argmax  out  STATE_ADDR_WIDTH+PE_NUM_WIDTH  index of the maximum probability.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. rst sampled high forces IDLE and zeros every output and internal counter, including mid-sweep. In-flight RAM data is discarded.
- Word count W:
  - W = 2^(i_qbit_num − PE_NUM_WIDTH).
  - i_qbit_num ≤ PE_NUM_WIDTH gives W = 1.
  - i_qbit_num > STATE_ADDR_WIDTH+PE_NUM_WIDTH clamps to 2^STATE_ADDR_WIDTH.
  - i_qbit_num is latched on start.
- Slot layout: slot p occupies i_state_dout[(p+1)*STATE_DATA_WIDTH−1 : p*STATE_DATA_WIDTH]. Basis index = addr*PE_NUM + p.
- FSM IDLE → READ → WAIT → EMIT → (READ | DONE) → IDLE:
  - IDLE: o_busy=0. i_start=1 latches the qubit count, clears addr, sum and argmax/max, then goes to READ.
  - READ (1 cycle): o_state_ena all-ones, o_state_addra=addr.
  - WAIT (RAM_RD_LAT cycles): ena low. On the last WAIT cycle, capture the full word into a PE_NUM-slot buffer.
  - EMIT: PE_NUM beats, p = 0..PE_NUM−1, one per accepted handshake.
    - Output register loaded on entry and after each accepted beat.
    - After beat PE_NUM−1 is accepted: addr+1 → READ, or DONE if addr = W−1.
  - DONE (1 cycle): o_done=1, then IDLE.
- Latency: i_start sampled at cycle 0 → o_valid first high at cycle RAM_RD_LAT+3.
- Arithmetic:
  - re and im are signed DATA_WIDTH.
  - p2 = re*re + im*im, full width 2*DATA_WIDTH+1, unsigned.
  - o_prob = p2 >> NUM_FRAC_BIT (truncate), saturated to 2^DATA_WIDTH−1.
- Accumulation on each accepted beat:
  - sum += o_prob, saturating at 2^SUM_WIDTH−1.
  - Argmax updates only on strictly greater prob, so ties keep the lowest index. An all-zero state gives argmax = 0.
- Handshake:
  - Beat transfers when o_valid & i_ready.
  - While o_valid & !i_ready, o_prob, o_index and o_last are held stable.
  - o_valid never drops without a transfer.
  - o_last=1 only on index W*PE_NUM−1.
- i_start while busy: ignored. i_start in the same cycle as rst: rst wins.
- The block never writes the RAM: o_state_wea=0 always.

Decomposition:
- Package qea_readout_pkg holds:
  - FSM state enum (IDLE, READ, WAIT, EMIT, DONE).
  - Constant ONE_FX = 1<<NUM_FRAC_BIT.
  - Function for the word-count clamp.
- One sub-module, qea_amp_to_prob: combinational {re, im} → saturated probability. Instantiated once and muxed by slot.

Test Plan:
- 4 qubits, word0 slot0 = 0x40000000_00000000, rest 0; start:
  - 16 beats; beat0 prob 0x40000000, others 0.
  - o_last on index 15; o_sum 0x40000000; o_argmax 0; o_done one cycle.
  - First o_valid at cycle 4 (RAM_RD_LAT=1).
- 4 qubits, all re=0x10000000, im=0: each prob 0x04000000; o_sum 0x40000000; o_argmax 0 (tie rule).
- re=im=0x20000000 at index 6, rest 0: prob[6] 0x20000000; o_argmax 6.
- re=im=0x80000000 at index 3: prob[3] saturates to 0xFFFFFFFF; sum equals 0xFFFFFFFF.
- i_ready low for 3 cycles at beat 5: o_prob/o_index held at index 5; no skipped or duplicated index; wea stays 0.
- i_qbit_num=2: exactly 1 RAM read, 4 beats. rst pulse during EMIT of word 2: all outputs 0 next cycle; a fresh start replays from index 0.
